pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath (master) supplies hazard sources; the controller (slave) returns enables and status.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_uses_rt;
   logic        ID_EX_MemtoReg;
   logic        ID_EX_RegWrite;
   logic [4:0]  ID_EX_dst;
   logic        EX_redirect;
   logic        mem_busy;
   logic        pc_write;
   logic        IF_ID_write;
   logic        IF_ID_flush;
   logic        ID_EX_bubble;
   logic        pipe_hold;
   logic        mem_timeout;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   modport master (
      output ID_rs, ID_rt, ID_uses_rt, ID_EX_MemtoReg, ID_EX_RegWrite, ID_EX_dst,
             EX_redirect, mem_busy,
      input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold,
             mem_timeout, stall_count, flush_count
   );

   modport slave (
      input  ID_rs, ID_rt, ID_uses_rt, ID_EX_MemtoReg, ID_EX_RegWrite, ID_EX_dst,
             EX_redirect, mem_busy,
      output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold,
             mem_timeout, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait hold, redirect flush, load-use bubble,
// plus a memory watchdog and saturating stall/flush statistics.
//
// state    | meaning
// RUN      | pipeline advancing normally (or stalling/flushing for one cycle)
// MEM_WAIT | data memory busy, whole pipeline frozen, wait counter running
module pipeline_hazard_ctrl (
   input logic                   clock,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        bubble_done;
   logic        mem_timeout;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   logic load_use;
   logic lu_stall;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_bubble;
   logic pipe_hold;

   assign load_use = hz.ID_EX_MemtoReg & hz.ID_EX_RegWrite & (hz.ID_EX_dst != 5'd0) &
                     ((hz.ID_EX_dst == hz.ID_rs) | (hz.ID_uses_rt & (hz.ID_EX_dst == hz.ID_rt)));

   // bubble_done keeps a held load-use pattern from inserting a second bubble
   assign lu_stall = ~reset & ~hz.mem_busy & ~hz.EX_redirect & load_use & ~bubble_done;

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
      if (reset) begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end else if (hz.mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (hz.EX_redirect) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (lu_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         bubble_done <= 1'b0;
         mem_timeout <= 1'b0;
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         if (hz.mem_busy) begin
            state <= MEM_WAIT;
            if (state == RUN) begin
               wait_cnt <= 8'd0;
            end else begin
               if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
               if (wait_cnt >= 8'd254) mem_timeout <= 1'b1;
            end
         end else begin
            state       <= RUN;
            bubble_done <= lu_stall;
         end
         if (!pc_write && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
         if (if_id_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      end
   end

   assign hz.pc_write     = pc_write;
   assign hz.IF_ID_write  = if_id_write;
   assign hz.IF_ID_flush  = if_id_flush;
   assign hz.ID_EX_bubble = id_ex_bubble;
   assign hz.pipe_hold    = pipe_hold;
   assign hz.mem_timeout  = mem_timeout;
   assign hz.stall_count  = stall_count;
   assign hz.flush_count  = flush_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios and
// randomized traffic against a cycle-level behavioural model of the priority rules.
module tb_pipeline_hazard_ctrl;
   logic clock;
   logic reset;
   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl dut (
      .clock (clock),
      .reset (reset),
      .hz    (hz.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // model state: consecutive busy cycles, sticky timeout, statistics, pending-bubble flag
   int busy_run;
   bit m_timeout;
   int m_stall;
   int m_flush;
   bit m_bubbled;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      busy_run  = 0;
      m_timeout = 1'b0;
      m_stall   = 0;
      m_flush   = 0;
      m_bubbled = 1'b0;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic mtr, input logic rw, input logic [4:0] dst,
                        input logic redir, input logic busy);
      hz.ID_rs          = rs;
      hz.ID_rt          = rt;
      hz.ID_uses_rt     = uses_rt;
      hz.ID_EX_MemtoReg = mtr;
      hz.ID_EX_RegWrite = rw;
      hz.ID_EX_dst      = dst;
      hz.EX_redirect    = redir;
      hz.mem_busy       = busy;
   endtask

   // called at a falling edge: apply inputs, check against model, advance one cycle
   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic mtr, input logic rw, input logic [4:0] dst,
                       input logic redir, input logic busy);
      bit lu;
      bit e_pc, e_ifw, e_fl, e_bub, e_hold;
      drive(rs, rt, uses_rt, mtr, rw, dst, redir, busy);
      #1;
      lu = mtr && rw && (dst != 0) && ((dst == rs) || (uses_rt && dst == rt));
      if (busy) begin
         e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_hold = 1;
      end else if (redir) begin
         e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1; e_hold = 0;
      end else if (lu && !m_bubbled) begin
         e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; e_hold = 0;
      end else begin
         e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
      end
      check_eq("pc_write",     32'(hz.pc_write),     32'(e_pc));
      check_eq("IF_ID_write",  32'(hz.IF_ID_write),  32'(e_ifw));
      check_eq("IF_ID_flush",  32'(hz.IF_ID_flush),  32'(e_fl));
      check_eq("ID_EX_bubble", 32'(hz.ID_EX_bubble), 32'(e_bub));
      check_eq("pipe_hold",    32'(hz.pipe_hold),    32'(e_hold));
      check_eq("mem_timeout",  32'(hz.mem_timeout),  32'(m_timeout));
      check_eq("stall_count",  32'(hz.stall_count),  32'(m_stall));
      check_eq("flush_count",  32'(hz.flush_count),  32'(m_flush));
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run >= 256) m_timeout = 1'b1;
      if (!e_pc && m_stall < 65535) m_stall++;
      if (e_fl && m_flush < 65535) m_flush++;
      if (!busy) m_bubbled = !redir && lu && !m_bubbled;
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      reset = 1'b1;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      model_clear();
      @(negedge clock);
      // reset dominates even with mem_busy asserted
      check_eq("rst_pc_write",    32'(hz.pc_write),     32'd1);
      check_eq("rst_IF_ID_write", 32'(hz.IF_ID_write),  32'd1);
      check_eq("rst_pipe_hold",   32'(hz.pipe_hold),    32'd0);
      check_eq("rst_flush",       32'(hz.IF_ID_flush),  32'd0);
      check_eq("rst_bubble",      32'(hz.ID_EX_bubble), 32'd0);
      check_eq("rst_timeout",     32'(hz.mem_timeout),  32'd0);
      check_eq("rst_stall_count", 32'(hz.stall_count),  32'd0);
      check_eq("rst_flush_count", 32'(hz.flush_count),  32'd0);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clock);

      // load to $5 in EX, ID reads $5: one bubble, then normal with inputs held
      step(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      step(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      check_eq("lu_stall_count", 32'(hz.stall_count), 32'd1);
      step(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

      // hazard through rt only
      do_reset();
      step(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      step(5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      check_eq("rt_stall_count", 32'(hz.stall_count), 32'd1);

      // register 0 never stalls
      do_reset();
      step(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      check_eq("r0_stall_count", 32'(hz.stall_count), 32'd0);

      // redirect beats load-use
      do_reset();
      step(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      step(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("redir_flush_count", 32'(hz.flush_count), 32'd1);
      check_eq("redir_stall_count", 32'(hz.stall_count), 32'd0);

      // mem_busy beats redirect for 3 cycles, then the flush happens
      do_reset();
      for (int i = 0; i < 3; i++) step(5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      step(5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check_eq("busy_stall_count", 32'(hz.stall_count), 32'd3);
      check_eq("busy_flush_count", 32'(hz.flush_count), 32'd1);

      // 300-cycle memory wait: watchdog fires after the 256th busy cycle and sticks
      do_reset();
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         if (i == 255) check_eq("timeout_before_256", 32'(hz.mem_timeout), 32'd0);
         if (i == 256) check_eq("timeout_at_256",     32'(hz.mem_timeout), 32'd1);
         step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      end
      for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("timeout_sticky", 32'(hz.mem_timeout), 32'd1);

      // async reset in the middle of a memory wait
      for (int i = 0; i < 4; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("areset_pc_write",    32'(hz.pc_write),    32'd1);
      check_eq("areset_IF_ID_write", 32'(hz.IF_ID_write), 32'd1);
      check_eq("areset_pipe_hold",   32'(hz.pipe_hold),   32'd0);
      check_eq("areset_timeout",     32'(hz.mem_timeout), 32'd0);
      check_eq("areset_stall_count", 32'(hz.stall_count), 32'd0);
      check_eq("areset_flush_count", 32'(hz.flush_count), 32'd0);
      @(negedge clock);
      hz.mem_busy = 1'b0;
      reset = 1'b0;
      model_clear();

      // randomized traffic with a small register pool to provoke collisions
      for (int n = 0; n < 2000; n++) begin
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
